mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single shared memory port.
// One transaction in flight; completion or timeout returns a one-cycle rvalid per port.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [1:0]          err,
    output logic [2*DATA_W-1:0] rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_sel,
    output logic                busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy0 = 2'd1,
        StBusy1 = 2'd2
    } state_e;

    // Counter value seen in the last BUSY cycle allowed before abort.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic                owner_q, owner_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [1:0]          err_q, err_d;
    logic [2*DATA_W-1:0] rdata_q, rdata_d;

    logic                win;
    logic                finish;
    logic [DATA_W-1:0]   cap;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rvalid_d   = 2'b00;
        err_d      = 2'b00;
        rdata_d    = rdata_q;
        gnt        = 2'b00;
        finish     = 1'b0;
        cap        = '0;

        // Tie goes to the port that was not served last.
        win = (req == 2'b11) ? ~last_gnt_q : req[1];

        unique case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    gnt     = win ? 2'b10 : 2'b01;
                    owner_d = win;
                    we_d    = we[win];
                    addr_d  = win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
                    wdata_d = win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
                    cnt_d   = 8'd0;
                    state_d = win ? StBusy1 : StBusy0;
                end
            end
            StBusy0, StBusy1: begin
                if (mem_ready) begin
                    finish = 1'b1;
                    cap    = we_q ? '0 : mem_rdata;
                end else if (cnt_q == WaitLast) begin
                    finish = 1'b1;
                    err_d  = owner_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (finish) begin
                    rvalid_d   = owner_q ? 2'b10 : 2'b01;
                    last_gnt_d = owner_q;
                    state_d    = StIdle;
                    if (owner_q) rdata_d[2*DATA_W-1:DATA_W] = cap;
                    else         rdata_d[DATA_W-1:0]        = cap;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            cnt_q      <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rvalid_q   <= 2'b00;
            err_q      <= 2'b00;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign mem_sel   = busy ? owner_q : last_gnt_q;
    assign rvalid    = rvalid_q;
    assign err       = err_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic,
// all compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req, we;
    logic [63:0]   addr, wdata;
    logic [1:0]    gnt, rvalid, err;
    logic [63:0]   rdata;
    logic          mem_req, mem_we, mem_ready, mem_sel, busy;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_sel(mem_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: which port is being served (-1 = nobody), its payload,
    // how many BUSY cycles have gone by without mem_ready, and the visible results.
    int          m_port;
    int          m_last;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    int          m_wait;
    logic [1:0]  e_rvalid, e_err;
    logic [63:0] e_rdata;

    task automatic model_reset();
        m_port = -1; m_last = 1; m_we = 0; m_addr = 0; m_wdata = 0; m_wait = 0;
        e_rvalid = 0; e_err = 0; e_rdata = 0;
    endtask

    function automatic int winner(input logic [1:0] r, input int last);
        if (r == 2'b11) return 1 - last;
        return r[1] ? 1 : 0;
    endfunction

    task automatic check_outputs();
        logic [1:0] eg;
        eg = 2'b00;
        if (m_port < 0 && req != 2'b00) eg = (winner(req, m_last) == 1) ? 2'b10 : 2'b01;
        check_eq("gnt", gnt, eg);
        check_eq("busy", busy, m_port >= 0);
        check_eq("mem_req", mem_req, m_port >= 0);
        check_eq("mem_we", mem_we, (m_port >= 0) ? m_we : 1'b0);
        check_eq("mem_addr", mem_addr, (m_port >= 0) ? m_addr : 32'h0);
        check_eq("mem_wdata", mem_wdata, (m_port >= 0) ? m_wdata : 32'h0);
        check_eq("mem_sel", mem_sel, (m_port >= 0) ? m_port : m_last);
        check_eq("rvalid", rvalid, e_rvalid);
        check_eq("err", err, e_err);
        check_eq("rdata", rdata, e_rdata);
    endtask

    task automatic model_step();
        int p;
        logic done;
        e_rvalid = 0;
        e_err    = 0;
        done     = 0;
        if (m_port < 0) begin
            if (req != 2'b00) begin
                p       = winner(req, m_last);
                m_port  = p;
                m_we    = we[p];
                m_addr  = addr[p*32 +: 32];
                m_wdata = wdata[p*32 +: 32];
                m_wait  = 0;
            end
        end else begin
            p = m_port;
            if (mem_ready) begin
                e_rdata[p*32 +: 32] = m_we ? 32'h0 : mem_rdata;
                done = 1;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    e_rdata[p*32 +: 32] = 32'h0;
                    e_err[p] = 1'b1;
                    done = 1;
                end
            end
            if (done) begin
                e_rvalid[p] = 1'b1;
                m_last = p;
                m_port = -1;
            end
        end
    endtask

    // One clock cycle: apply inputs after the edge, check and advance the model mid-cycle.
    task automatic drive_cycle(input logic [1:0] r, input logic [1:0] w, input logic [63:0] a,
                               input logic [63:0] d, input logic rdy, input logic [31:0] rd);
        req = r; we = w; addr = a; wdata = d; mem_ready = rdy; mem_rdata = rd;
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 32'h0);
    endtask

    initial begin
        rst_n = 1'b1;
        req = 0; we = 0; addr = 0; wdata = 0; mem_ready = 0; mem_rdata = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_rvalid", rvalid, 2'b00);
        check_eq("rst_rdata", rdata, 64'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Tie right after reset: port 0 first, then strict alternation.
        drive_cycle(2'b11, 2'b00, 64'h0000_0004_0000_0008, 64'h0, 1'b1, 32'h0);
        check_eq("tie_first_owner", mem_sel, 1'b0);
        for (int i = 0; i < 7; i++)
            drive_cycle(2'b11, 2'b00, 64'h0000_0004_0000_0008, 64'h0, 1'b1, 32'hA5A5_0000 + i);
        idle_cycles(2);

        // Read with three wait states.
        drive_cycle(2'b01, 2'b00, 64'h0000_0000_0000_0100, 64'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) drive_cycle(2'b00, 2'b00, 64'h0, 64'h0, 1'b0, 32'h0);
        drive_cycle(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 32'hDEAD_BEEF);
        check_eq("rd_rvalid", rvalid, 2'b01);
        check_eq("rd_err", err, 2'b00);
        check_eq("rd_rdata0", rdata[31:0], 32'hDEAD_BEEF);
        idle_cycles(1);

        // Write from port 1.
        drive_cycle(2'b10, 2'b10, 64'h0000_0020_0000_0000, 64'h1234_5678_0000_0000, 1'b0, 32'h0);
        check_eq("wr_mem_we", mem_we, 1'b1);
        check_eq("wr_mem_addr", mem_addr, 32'h20);
        check_eq("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        check_eq("wr_mem_sel", mem_sel, 1'b1);
        drive_cycle(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 32'hFFFF_FFFF);
        check_eq("wr_rvalid", rvalid, 2'b10);
        check_eq("wr_rdata1", rdata[63:32], 32'h0);
        idle_cycles(1);

        // Timeout on port 0: sixteen BUSY cycles with no mem_ready.
        drive_cycle(2'b01, 2'b00, 64'h44, 64'h0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) drive_cycle(2'b00, 2'b00, 64'h0, 64'h0, 1'b0, 32'h0);
        check_eq("to_still_busy", busy, 1'b1);
        drive_cycle(2'b00, 2'b00, 64'h0, 64'h0, 1'b0, 32'h0);
        check_eq("to_rvalid", rvalid, 2'b01);
        check_eq("to_err", err, 2'b01);
        check_eq("to_rdata0", rdata[31:0], 32'h0);
        check_eq("to_idle", busy, 1'b0);
        idle_cycles(1);

        // Reset in the second BUSY1 cycle while mem_ready is high.
        drive_cycle(2'b10, 2'b10, 64'h0000_0030_0000_0000, 64'h0000_0077_0000_0000, 1'b0, 32'h0);
        drive_cycle(2'b00, 2'b00, 64'h0, 64'h0, 1'b0, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mr_busy", busy, 1'b0);
        check_eq("mr_mem_req", mem_req, 1'b0);
        check_eq("mr_mem_we", mem_we, 1'b0);
        check_eq("mr_mem_addr", mem_addr, 32'h0);
        check_eq("mr_mem_wdata", mem_wdata, 32'h0);
        check_eq("mr_rvalid", rvalid, 2'b00);
        check_eq("mr_err", err, 2'b00);
        check_eq("mr_rdata", rdata, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_cycle(2'b11, 2'b00, 64'h0, 64'h0, 1'b1, 32'h0);
        check_eq("mr_tie_owner", mem_sel, 1'b0);
        idle_cycles(2);

        // Request dropped after grant: transaction still completes.
        drive_cycle(2'b01, 2'b00, 64'h0000_0000_0000_0200, 64'h0, 1'b0, 32'h0);
        drive_cycle(2'b00, 2'b00, 64'h0, 64'h0, 1'b0, 32'h0);
        check_eq("drop_mem_req", mem_req, 1'b1);
        drive_cycle(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 32'h0BAD_F00D);
        check_eq("drop_rvalid", rvalid, 2'b01);
        check_eq("drop_rdata0", rdata[31:0], 32'h0BAD_F00D);
        idle_cycles(1);

        // Random traffic; mem_ready rarity varies to reach both fast completions and timeouts.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  r, w;
            logic [63:0] a, d;
            logic        rdy;
            int          thr;
            thr = (i < 1500) ? 5 : 1;
            r   = 2'($urandom_range(0, 3));
            w   = 2'($urandom_range(0, 3));
            a   = {$urandom(), $urandom()};
            d   = {$urandom(), $urandom()};
            rdy = ($urandom_range(0, 9) < thr);
            drive_cycle(r, w, a, d, rdy, $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
